// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU controller with MULT/DIV sequencer:
// ALU and bonus select codes, R-type funct constants, sequencer states.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1011;
  localparam logic [3:0] ALU_DIV   = 4'b1100;
  localparam logic [3:0] ALU_SHIFT = 4'b1111;

  localparam logic [2:0] BONUS_NONE   = 3'b000;
  localparam logic [2:0] BONUS_JR     = 3'b010;
  localparam logic [2:0] BONUS_VSHIFT = 3'b101;

  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_JR   = 6'b001000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALUOp/funct decode into ALU, bonus and shamt-shift
// selects, plus flags marking MULT/DIV for the sequencer.
// Build option: ALU_CTRL_DIV_EN enables DIV decode; without it 011010 is
// treated as a plain shift-class funct with no bonus and never starts the MDU.
module alu_ctrl_decode #(
  parameter int CTRL_W  = 4,
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic [2:0]         alu_op,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic [2:0]         bonus,
  output logic               shift,
  output logic               is_mdu,
  output logic               is_div
);
  import alu_ctrl_pkg::*;

  logic [5:0] f;
  assign f = funct[5:0];

  // Decode ALUOp class first; only R-type classes look at funct.
  always_comb begin
    alu_ctrl = CTRL_W'(ALU_ADD);
    bonus    = BONUS_NONE;
    shift    = 1'b0;
    is_mdu   = 1'b0;
    is_div   = 1'b0;
    if (alu_op[2]) begin
      alu_ctrl = CTRL_W'({1'b0, alu_op[1:0]});
    end else if (alu_op == OP_SUB) begin
      alu_ctrl = CTRL_W'(ALU_SUB);
    end else if (f[5]) begin
      case (f)
        F_SUB:   alu_ctrl = CTRL_W'(ALU_SUB);
        F_AND:   alu_ctrl = CTRL_W'(ALU_AND);
        F_OR:    alu_ctrl = CTRL_W'(ALU_OR);
        F_SLT:   alu_ctrl = CTRL_W'(ALU_SLT);
        default: alu_ctrl = CTRL_W'(ALU_ADD);
      endcase
    end else begin
      shift = ~(f[4] & f[3]) & ~f[2];
      case (f)
        F_MULT: begin
          alu_ctrl = CTRL_W'(ALU_MULT);
          is_mdu   = 1'b1;
        end
`ifdef ALU_CTRL_DIV_EN
        F_DIV: begin
          alu_ctrl = CTRL_W'(ALU_DIV);
          is_mdu   = 1'b1;
          is_div   = 1'b1;
        end
`else
        // funct[1] is set here, but this code must not pick the variable-shift bonus
        F_DIV: alu_ctrl = CTRL_W'(ALU_SHIFT);
`endif
        F_JR: begin
          alu_ctrl = CTRL_W'(ALU_ADD);
          bonus    = BONUS_JR;
        end
        default: begin
          alu_ctrl = CTRL_W'(ALU_SHIFT);
          bonus    = f[1] ? BONUS_VSHIFT : BONUS_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu_seq.sv
// ALU controller with registered EX controls and a counter-based MULT/DIV
// sequencer that stalls the front end and pulses the HI/LO write.
// Build option: ALU_CTRL_DIV_EN (DIV support, handled in alu_ctrl_decode).
//
// state  | meaning
// IDLE   | no MDU op in flight; a valid MULT/DIV starts one
// RUN    | MDU busy, front end stalled, counter runs down to 0
// DONE   | result ready, HI/LO written; may start the next op at once
module alu_ctrl_mdu_seq #(
  parameter int CTRL_W  = 4,
  parameter int FUNCT_W = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [2:0]         ALUOp_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic [2:0]         BonusCtrl_o,
  output logic               ALUShift_o,
  output logic               mdu_start_o,
  output logic               mdu_op_o,
  output logic               hilo_we_o,
  output logic               stall_o
);
  import alu_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [2:0]        dec_bonus;
  logic              dec_shift;
  logic              dec_mdu;
  logic              dec_div;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              issue;
  logic              start;
  logic              mdu_op_q;

  alu_ctrl_decode #(
    .CTRL_W  (CTRL_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .funct    (funct_i),
    .alu_op   (ALUOp_i),
    .alu_ctrl (dec_ctrl),
    .bonus    (dec_bonus),
    .shift    (dec_shift),
    .is_mdu   (dec_mdu),
    .is_div   (dec_div)
  );

  assign stall_o     = (state_q == S_RUN);
  assign issue       = valid_i & dec_mdu & ~flush_i;
  // start is Mealy on the inputs, so keep it quiet while reset is asserted
  assign mdu_start_o = start & ~rst_i;
  assign mdu_op_o    = mdu_op_q;

  // EX control registers: capture decode whenever ID/EX advances.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ALUCtrl_o   <= '0;
      BonusCtrl_o <= '0;
      ALUShift_o  <= 1'b0;
    end else if (valid_i && !stall_o) begin
      ALUCtrl_o   <= dec_ctrl;
      BonusCtrl_o <= dec_bonus;
      ALUShift_o  <= dec_shift;
    end
  end

  // Sequencer state, counter and latched MDU op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mdu_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) mdu_op_q <= dec_div;
    end
  end

  // Next state, counter load/decrement and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    hilo_we_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_RUN;
          start   = 1'b1;
          cnt_d   = dec_div ? DIV_LD : MUL_LD;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          hilo_we_o = 1'b1;
          if (issue) begin
            state_d = S_RUN;
            start   = 1'b1;
            cnt_d   = dec_div ? DIV_LD : MUL_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_mdu_seq.sv
// Scoreboard bench for alu_ctrl_mdu_seq: a cycle-numbered reference model
// predicts every output per cycle; a monitor pops and compares at negedge.
module tb_alu_ctrl_mdu_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [5:0] funct_i = '0;
  logic [2:0] ALUOp_i = '0;
  logic [3:0] ALUCtrl_o;
  logic [2:0] BonusCtrl_o;
  logic       ALUShift_o, mdu_start_o, mdu_op_o, hilo_we_o, stall_o;

  alu_ctrl_mdu_seq #(
    .CTRL_W(4), .FUNCT_W(6), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .funct_i(funct_i), .ALUOp_i(ALUOp_i), .ALUCtrl_o(ALUCtrl_o),
    .BonusCtrl_o(BonusCtrl_o), .ALUShift_o(ALUShift_o), .mdu_start_o(mdu_start_o),
    .mdu_op_o(mdu_op_o), .hilo_we_o(hilo_we_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [2:0] bonus;
    logic       shift;
  } dec_t;

  typedef struct packed {
    dec_t regs;
    logic stall;
    logic start;
    logic hilo;
    logic op_chk;
    logic op;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // reference model state: one MDU op described by its issue cycle and length
  bit   op_act = 1'b0;
  int   op_start = 0;
  int   op_lat = 0;
  bit   op_div = 1'b0;
  dec_t view = '0;

  function automatic dec_t ref_decode(input logic [2:0] aop, input logic [5:0] f);
    dec_t d;
    d = '0;
    d.ctrl = 4'b0010;
    if (aop[2]) d.ctrl = {2'b00, aop[1:0]};
    else if (aop == 3'b011) d.ctrl = 4'b0110;
    else if (f[5]) begin
      case (f)
        6'b100010: d.ctrl = 4'b0110;
        6'b100100: d.ctrl = 4'b0000;
        6'b100101: d.ctrl = 4'b0001;
        6'b101010: d.ctrl = 4'b0111;
        default:   d.ctrl = 4'b0010;
      endcase
    end else begin
      d.shift = !(f[4] && f[3]) && !f[2];
      if (f == FN_MULT) d.ctrl = 4'b1011;
      else if (f == FN_DIV && DIV_EN) d.ctrl = 4'b1100;
      else if (f == 6'b001000) begin
        d.ctrl  = 4'b0010;
        d.bonus = 3'b010;
      end else begin
        d.ctrl  = 4'b1111;
        d.bonus = (f[1] && f != FN_DIV) ? 3'b101 : 3'b000;
      end
    end
    return d;
  endfunction

  function automatic bit ref_is_mdu(input logic [2:0] aop, input logic [5:0] f);
    return !aop[2] && aop != 3'b011 && (f == FN_MULT || (DIV_EN && f == FN_DIV));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_alu_ctrl", 32'(ALUCtrl_o), 0);
    chk("rst_bonus", 32'(BonusCtrl_o), 0);
    chk("rst_shift", 32'(ALUShift_o), 0);
    chk("rst_start", 32'(mdu_start_o), 0);
    chk("rst_mdu_op", 32'(mdu_op_o), 0);
    chk("rst_hilo_we", 32'(hilo_we_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
  endtask

  // Drive one cycle of stimulus and push the model's prediction for it.
  task automatic step(input bit v, input bit fl, input logic [2:0] aop, input logic [5:0] f);
    exp_t e;
    bit   in_done;
    @(posedge clk);
    #1;
    valid_i = v;
    flush_i = fl;
    ALUOp_i = aop;
    funct_i = f;
    cyc++;
    e.regs   = view;
    e.stall  = op_act && (cyc > op_start) && (cyc <= op_start + op_lat);
    in_done  = op_act && (cyc == op_start + op_lat + 1);
    e.hilo   = in_done && !fl;
    e.op_chk = op_act && (cyc > op_start) && (cyc <= op_start + op_lat + 1);
    e.op     = op_div;
    e.start  = v && ref_is_mdu(aop, f) && !fl && !e.stall;
    if (in_done || (fl && e.stall)) op_act = 1'b0;
    if (e.start) begin
      op_act   = 1'b1;
      op_start = cyc;
      op_div   = (f == FN_DIV);
      op_lat   = op_div ? DIV_LAT : MUL_LAT;
    end
    if (v && !e.stall) view = ref_decode(aop, f);
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    op_act = 1'b0;
    view   = '0;
  endtask

  // Monitor: compare every predicted cycle at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("alu_ctrl", 32'(ALUCtrl_o), 32'(e.regs.ctrl));
        chk("bonus", 32'(BonusCtrl_o), 32'(e.regs.bonus));
        chk("shift", 32'(ALUShift_o), 32'(e.regs.shift));
        chk("stall", 32'(stall_o), 32'(e.stall));
        chk("start", 32'(mdu_start_o), 32'(e.start));
        chk("hilo_we", 32'(hilo_we_o), 32'(e.hilo));
        if (e.op_chk) chk("mdu_op", 32'(mdu_op_o), 32'(e.op));
      end
    end
  end

  logic [5:0] fn_tab [12];

  initial begin : stim
    bit         v, fl;
    logic [2:0] aop;
    logic [5:0] f;
    int         k;
    fn_tab = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000, FN_MULT,
               FN_DIV, 6'b001000, 6'b000000, 6'b000110, 6'b000011, 6'b100111};

    // power-on reset
    #2;
    chk_reset_outputs();
    @(negedge clk);
    #1 rst_i = 1'b0;
    model_reset();

    // SLT via R-type class
    step(1, 0, 3'b010, FN_SLT);
    step(0, 0, 3'b010, FN_ADD);
    step(0, 0, 3'b010, FN_ADD);

    // MULT with the next op held in ID across the stall
    step(1, 0, 3'b010, FN_MULT);
    repeat (7) step(1, 0, 3'b010, FN_ADD);

    // MULT, then DIV waiting in ID so it issues in the DONE cycle
    step(1, 0, 3'b010, FN_MULT);
    repeat (5) step(1, 0, 3'b010, FN_DIV);
    repeat (DIV_LAT + 3) step(1, 0, 3'b010, FN_ADD);

    // flush in the second RUN cycle
    step(1, 0, 3'b010, FN_MULT);
    step(1, 0, 3'b010, FN_ADD);
    step(1, 1, 3'b010, FN_ADD);
    repeat (6) step(1, 0, 3'b010, FN_ADD);

    // flush in DONE while another MULT tries to issue
    step(1, 0, 3'b010, FN_MULT);
    repeat (4) step(1, 0, 3'b010, FN_MULT);
    step(1, 1, 3'b010, FN_MULT);
    repeat (3) step(1, 0, 3'b010, FN_SLT);

    // flush with an issuing MULT from IDLE
    step(1, 1, 3'b010, FN_MULT);
    repeat (2) step(0, 0, 3'b010, FN_ADD);

    // asynchronous reset pulse in the middle of a MULT
    step(1, 0, 3'b010, FN_MULT);
    step(1, 0, 3'b010, FN_ADD);
    step(1, 0, 3'b010, FN_ADD);
    @(posedge clk);
    #3;
    valid_i = 1'b0;
    flush_i = 1'b0;
    rst_i   = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs();
    #1 rst_i = 1'b0;
    model_reset();
    repeat (8) step(1, 0, 3'b010, FN_ADD);

    // randomized traffic
    repeat (3000) begin
      v  = ($urandom_range(0, 99) < 85);
      fl = ($urandom_range(0, 99) < 5);
      k  = $urandom_range(0, 9);
      if (k == 0) aop = 3'b011;
      else if (k == 1) aop = {1'b1, 2'($urandom_range(0, 3))};
      else aop = 3'b010;
      k = $urandom_range(0, 13);
      if (k < 12) f = fn_tab[k];
      else f = 6'($urandom_range(0, 63));
      step(v, fl, aop, f);
    end

    repeat (4) step(0, 0, 3'b010, FN_ADD);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
